dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester round-robin arbiter and access sequencer for the single-port, synchronous-read 8-bit data memory (backed range 64..255). Requester 0 is the CPU load/store stage; requester 1 is the loader/debug port. Accepts one access at a time and drives the memory's address, write-data and write-enable pins. Returns read data or a write acknowledge two cycles after acceptance.

Parameters:
ADDR_W, 8, address width of requests and memory.
DATA_W, 8, data width.
MEM_BASE, 64, lowest backed memory address (used only when DMEM_RANGE_CHECK_EN is defined).

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
r0_valid  in  1  requester 0 access request
r0_ready  out  1  requester 0 accepted this cycle
r0_we  in  1  1=write, 0=read
r0_addr  in  ADDR_W  access address
r0_wdata  in  DATA_W  write data
r0_resp_valid  out  1  one-cycle response pulse
r0_rdata  out  DATA_W  read data, valid with r0_resp_valid
r0_err  out  1  access rejected, valid with r0_resp_valid
r1_valid, r1_ready, r1_we, r1_addr, r1_wdata, r1_resp_valid, r1_rdata, r1_err: as r0_* for requester 1
mem_addr  out  ADDR_W  to memory data_address
mem_we  out  1  to memory write_enable
mem_wdata  out  DATA_W  to memory write_data
mem_rdata  in  DATA_W  from memory read_data (registered in memory)
busy  out  1  high in ISSUE and RESP

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Reset: state=IDLE, last_grant=1 (requester 0 wins first tie), all outputs 0, capture registers 0.
- IDLE:
  - grant computed combinationally. Only one valid -> that requester. Both valid -> requester != last_grant.
  - rN_ready = grant to N (only in IDLE, only when rN_valid). Handshake completes when valid & ready at posedge.
  - On handshake: capture we/addr/wdata/requester id, set last_grant=id, go ISSUE.
  - No valid -> stay IDLE, no ready.
- ISSUE (cycle T+1, T = accept cycle):
  - mem_addr/mem_wdata = captured values.
  - mem_we = captured we.
  - Memory writes or latches read data at the end of this cycle. Next state RESP.
- RESP (T+2):
  - rN_resp_valid=1 for owner only; rN_rdata = mem_rdata for reads, 0 for writes; rN_err=0.
  - Next state IDLE. No acceptance in RESP.
  - Throughput: one access per 3 cycles.
- Outside ISSUE: mem_we=0. mem_addr/mem_wdata hold the last captured values.
- rN_ready, rN_resp_valid, rN_err are never asserted for both requesters in the same cycle.
- Requester may drop valid before ready with no effect. Inputs are sampled only at the handshake, so later changes do not affect an in-flight access.
- Reset mid-operation (ISSUE or RESP): return to IDLE next cycle.
  - Pending response discarded; no resp_valid issued.
  - mem_we forced 0 in the reset cycle and after.
  - last_grant=1.
- Write then read of the same address by either requester: the read returns new data (accesses are strictly serialised).

Optional Feature:
DMEM_RANGE_CHECK_EN
- Defined:
  - An accepted request with addr < MEM_BASE does not touch memory; mem_we stays 0 in ISSUE.
  - RESP: resp_valid=1, err=1, rdata=0.
  - Timing and arbitration unchanged.
- Not defined:
  - All addresses pass through to memory; rN_err tied 0.
  - Accesses below MEM_BASE hit unbacked locations; result undefined, not checked.

Test Plan:
- Single read: memory preloaded [100]=0x5A; r0 read addr 100 at cycle T -> r0_ready at T, mem_we=0 at T+1, r0_resp_valid=1 with r0_rdata=0x5A at T+2, busy T+1..T+2.
- Write-then-read: r1 write addr 200 data 0xC3, then r1 read 200 -> mem_we=1 only in write's ISSUE cycle; write resp rdata=0; read resp rdata=0xC3.
- Contention: r0 and r1 both valid continuously from reset, reads of 70 and 71 -> grants alternate r0,r1,r0,r1 every 3 cycles; r0 served first; no double ready/resp.
- Reset mid-op: r0 write addr 80 data 0x11 accepted, reset asserted in ISSUE cycle -> no r0_resp_valid, state IDLE next cycle, mem_we=0 during reset, next tie goes to r0.
- Range check (macro defined): r0 write addr 10 -> mem_we stays 0, r0_err=1, r0_rdata=0 at T+2; macro undefined -> mem_we=1 at T+1, r0_err=0.
- Valid withdrawal: r1_valid pulsed while FSM in RESP and dropped before IDLE -> no r1_ready, no memory access.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter and access sequencer for a
// single-port, synchronous-read data memory. One access is in flight at a
// time. It is accepted in IDLE, driven to the memory in ISSUE, and answered
// in RESP, two cycles after acceptance.
//
// Optional feature: define DMEM_RANGE_CHECK_EN to reject addresses below
// MEM_BASE. A rejected access leaves the memory untouched and returns err=1.
//
// Handshake: a request transfers on a posedge where rN_valid & rN_ready are
// both high. rN_ready is only raised in IDLE, for the granted requester, and
// while its valid is high. A requester may drop valid at any time before
// ready with no effect. Responses are a one-cycle rN_resp_valid pulse with no
// back-pressure.
//
// fsm_state exposes the sequencer state (0=IDLE, 1=ISSUE, 2=RESP) for debug.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MEM_BASE = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_resp_valid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_resp_valid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]        state;
  logic              last_grant;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_id;
  logic              cap_err;

  logic              gnt_valid;
  logic              gnt_id;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;
  logic              in_resp;
  logic [DATA_W-1:0] resp_data;

  // Round-robin grant: a lone requester wins; on a tie the requester that
  // was not granted last time wins.
  always_comb begin
    gnt_valid = r0_valid | r1_valid;
    if (r0_valid && r1_valid) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = ~r0_valid;
    end
  end

  // Mux the granted requester's fields so the capture logic sees one source.
  always_comb begin
    sel_we    = gnt_id ? r1_we    : r0_we;
    sel_addr  = gnt_id ? r1_addr  : r0_addr;
    sel_wdata = gnt_id ? r1_wdata : r0_wdata;
  end

`ifdef DMEM_RANGE_CHECK_EN
  // Addresses below the backed range are rejected at acceptance time.
  assign sel_err = (sel_addr < ADDR_W'(MEM_BASE));
`else
  // Without range checking every address goes straight to the memory; the
  // comparison is kept only so MEM_BASE stays referenced.
  logic unused_base;
  assign unused_base = (sel_addr < ADDR_W'(MEM_BASE));
  assign sel_err     = 1'b0;
`endif

  // Acceptance is suppressed while reset is high so no handshake completes
  // in a reset cycle.
  assign accept   = (state == S_IDLE) && gnt_valid && !reset;
  assign r0_ready = accept && !gnt_id;
  assign r1_ready = accept &&  gnt_id;

  // Sequencer state, arbitration history and captured request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_id     <= 1'b0;
      cap_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_we     <= sel_we;
            cap_addr   <= sel_addr;
            cap_wdata  <= sel_wdata;
            cap_id     <= gnt_id;
            cap_err    <= sel_err;
            last_grant <= gnt_id;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory pins: address and data hold the last captured request; the write
  // strobe fires only in ISSUE for a non-rejected write, never during reset.
  always_comb begin
    mem_addr  = cap_addr;
    mem_wdata = cap_wdata;
    mem_we    = (state == S_ISSUE) && cap_we && !cap_err && !reset;
  end

  // Response steering: only the owner of the in-flight access sees a pulse;
  // a reset in RESP discards the response.
  always_comb begin
    in_resp       = (state == S_RESP) && !reset;
    resp_data     = (cap_we || cap_err) ? '0 : mem_rdata;
    r0_resp_valid = in_resp && !cap_id;
    r1_resp_valid = in_resp &&  cap_id;
    r0_rdata      = r0_resp_valid ? resp_data : '0;
    r1_rdata      = r1_resp_valid ? resp_data : '0;
    r0_err        = r0_resp_valid && cap_err;
    r1_err        = r1_resp_valid && cap_err;
  end

  // Status outputs.
  always_comb begin
    busy      = (state == S_ISSUE) || (state == S_RESP);
    fsm_state = state;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural synchronous-read
// memory model. Expected values are hand-computed per scenario.
module tb_dmem_arbiter;

  logic       clk;
  logic       reset;
  logic       r0_valid, r0_ready, r0_we, r0_resp_valid, r0_err;
  logic [7:0] r0_addr, r0_wdata, r0_rdata;
  logic       r1_valid, r1_ready, r1_we, r1_resp_valid, r1_err;
  logic [7:0] r1_addr, r1_wdata, r1_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic       busy;
  logic [1:0] fsm_state;

  logic [7:0] mem [0:255];
  logic [7:0] exp_q [$];
  int         total;
  int         bad;
  logic       exp_we_low;
  logic       exp_err_low;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_BASE(64)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_resp_valid(r0_resp_valid),
    .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_resp_valid(r1_resp_valid),
    .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .fsm_state(fsm_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read single-port memory model
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h3C);
    mem[100] = 8'h5A;
    mem[70]  = 8'h70;
    mem[71]  = 8'h71;
    mem[80]  = 8'hEE;
    mem_rdata = 8'h00;
`ifdef DMEM_RANGE_CHECK_EN
    exp_we_low  = 1'b0;
    exp_err_low = 1'b1;
`else
    exp_we_low  = 1'b1;
    exp_err_low = 1'b0;
`endif
    reset = 1'b1;
    drive0(1'b0, 1'b0, 8'h00, 8'h00);
    drive1(1'b0, 1'b0, 8'h00, 8'h00);
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_state", fsm_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_resp", {r0_resp_valid, r1_resp_valid, r0_err, r1_err}, 0);
    chk("rst_ready", {r0_ready, r1_ready}, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // Single read of 100 by r0
    drive0(1'b1, 1'b0, 8'd100, 8'h00);
    #1;
    chk("rd_ready", {r0_ready, r1_ready}, 2'b10);
    chk("rd_busy_t", busy, 0);
    cyc();
    drive0(1'b0, 1'b1, 8'd7, 8'hFF);
    #1;
    chk("rd_issue_state", fsm_state, 1);
    chk("rd_issue_busy", busy, 1);
    chk("rd_issue_we", mem_we, 0);
    chk("rd_issue_addr", mem_addr, 100);
    cyc();
    chk("rd_resp_valid", {r0_resp_valid, r1_resp_valid}, 2'b10);
    chk("rd_rdata", r0_rdata, 8'h5A);
    chk("rd_err", r0_err, 0);
    chk("rd_resp_busy", busy, 1);
    cyc();
    chk("rd_done_busy", busy, 0);
    chk("rd_done_resp", r0_resp_valid, 0);

    // Write 200=C3 then read 200 by r1
    drive1(1'b1, 1'b1, 8'd200, 8'hC3);
    #1;
    chk("wr_ready", {r0_ready, r1_ready}, 2'b01);
    cyc();
    drive1(1'b0, 1'b0, 8'd0, 8'h00);
    #1;
    chk("wr_issue_we", mem_we, 1);
    chk("wr_issue_addr", mem_addr, 200);
    chk("wr_issue_wdata", mem_wdata, 8'hC3);
    cyc();
    chk("wr_resp", {r0_resp_valid, r1_resp_valid}, 2'b01);
    chk("wr_rdata", r1_rdata, 0);
    chk("wr_resp_we", mem_we, 0);
    cyc();
    drive1(1'b1, 1'b0, 8'd200, 8'h00);
    #1;
    chk("rb_ready", r1_ready, 1);
    cyc();
    drive1(1'b0, 1'b0, 8'd0, 8'h00);
    #1;
    chk("rb_issue_we", mem_we, 0);
    cyc();
    chk("rb_resp", r1_resp_valid, 1);
    chk("rb_rdata", r1_rdata, 8'hC3);
    cyc();

    // Contention from reset: r0 reads 70, r1 reads 71
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive0(1'b1, 1'b0, 8'd70, 8'h00);
    drive1(1'b1, 1'b0, 8'd71, 8'h00);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("ct_ready", {r0_ready, r1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
      exp_q.push_back((k % 2 == 0) ? 8'h70 : 8'h71);
      cyc();
      chk("ct_issue_ready", {r0_ready, r1_ready}, 2'b00);
      chk("ct_issue_addr", mem_addr, (k % 2 == 0) ? 70 : 71);
      cyc();
      chk("ct_resp", {r0_resp_valid, r1_resp_valid}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("ct_rdata", (k % 2 == 0) ? r0_rdata : r1_rdata, exp_q.pop_front());
      chk("ct_resp_ready", {r0_ready, r1_ready}, 2'b00);
      @(posedge clk);
    end
    #1;
    drive0(1'b0, 1'b0, 8'd0, 8'h00);
    drive1(1'b0, 1'b0, 8'd0, 8'h00);
    cyc();

    // Reset during ISSUE of an r0 write 80=11 (last grant was r1 -> r0 wins)
    drive0(1'b1, 1'b1, 8'd80, 8'h11);
    #1;
    chk("rm_ready", r0_ready, 1);
    cyc();
    drive0(1'b0, 1'b0, 8'd0, 8'h00);
    reset = 1'b1;
    #1;
    chk("rm_we_in_reset", mem_we, 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rm_state", fsm_state, 0);
    chk("rm_no_resp", r0_resp_valid, 0);
    chk("rm_busy", busy, 0);
    drive0(1'b1, 1'b0, 8'd80, 8'h00);
    drive1(1'b1, 1'b0, 8'd71, 8'h00);
    #1;
    chk("rm_tie", {r0_ready, r1_ready}, 2'b10);
    cyc();
    drive0(1'b0, 1'b0, 8'd0, 8'h00);
    drive1(1'b0, 1'b0, 8'd0, 8'h00);
    cyc();
    chk("rm_rd80_resp", r0_resp_valid, 1);
    chk("rm_rd80_data", r0_rdata, 8'hEE);
    cyc();

    // Access below the backed range: r0 write 10=22
    drive0(1'b1, 1'b1, 8'd10, 8'h22);
    #1;
    chk("lo_ready", r0_ready, 1);
    cyc();
    drive0(1'b0, 1'b0, 8'd0, 8'h00);
    #1;
    chk("lo_issue_we", mem_we, exp_we_low);
    cyc();
    chk("lo_resp", r0_resp_valid, 1);
    chk("lo_err", r0_err, exp_err_low);
    chk("lo_rdata", r0_rdata, 0);
    cyc();

    // r1 valid pulsed in RESP and withdrawn before IDLE
    drive0(1'b1, 1'b0, 8'd100, 8'h00);
    #1;
    chk("wd_r0_ready", r0_ready, 1);
    cyc();
    drive0(1'b0, 1'b0, 8'd0, 8'h00);
    cyc();
    drive1(1'b1, 1'b1, 8'd90, 8'h99);
    #1;
    chk("wd_resp_ready", {r0_ready, r1_ready}, 2'b00);
    chk("wd_resp_data", r0_rdata, 8'h5A);
    cyc();
    drive1(1'b0, 1'b0, 8'd0, 8'h00);
    #1;
    chk("wd_idle_ready", r1_ready, 0);
    chk("wd_idle_state", fsm_state, 0);
    cyc();
    chk("wd_stay_idle", fsm_state, 0);
    chk("wd_no_we", mem_we, 0);
    chk("wd_no_resp", r1_resp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
